// File: rtl/ternary_adder_serial_signed_if.sv
// rtl/ternary_adder_serial_signed_if.sv - operand/result stream bundle for the serial signed ternary adder
interface ternary_adder_serial_signed_if #(
  parameter int width = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic [1:0]       in_mode;
  logic [1:0]       in_index;
  logic             out_valid;
  logic             out_ready;
  logic [width+1:0] out_data;

  // The adder is the slave of the operand stream and the source of results.
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, in_index, out_valid, out_data
  );

  // The environment drives operands and consumes results.
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, in_index, out_valid, out_data
  );
endinterface

// File: rtl/ternary_adder_serial_signed.sv
// rtl/ternary_adder_serial_signed.sv - serial-input signed ternary adder with per-triplet add/sub mode
module ternary_adder_serial_signed #(
  parameter int width = 8
) (
  input logic                       clk,
  input logic                       reset,
  ternary_adder_serial_signed_if.slave bus
);
  // Two guard bits cover the worst case of 3 * 2^(width-1) exactly.
  localparam int AW = width + 2;

  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [1:0]    mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_data_q, out_data_d;

  logic          in_ready;
  logic          accept;
  logic          subtract_b;
  logic          subtract_c;
  logic [AW-1:0] opnd_ext;

  // Sign-extend the incoming operand to accumulator width.
  assign opnd_ext = {{2{bus.in_data[width-1]}}, bus.in_data};

  // The last beat of a triplet may only enter when the result register can take it.
  assign in_ready = (cnt_q != 2'd2) || !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Mode 0/1 add b; mode 2/3 subtract b. Only mode 0 adds c.
  assign subtract_b = mode_q[1];
  assign subtract_c = (mode_q != 2'd0);

  // Next-state: step the beat counter and fold each accepted operand into the sum.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      case (cnt_q)
        2'd0: begin
          acc_d  = opnd_ext;
          mode_d = bus.in_mode;
          cnt_d  = 2'd1;
        end
        2'd1: begin
          acc_d = subtract_b ? (acc_q - opnd_ext) : (acc_q + opnd_ext);
          cnt_d = 2'd2;
        end
        default: begin
          out_data_d  = subtract_c ? (acc_q - opnd_ext) : (acc_q + opnd_ext);
          out_valid_d = 1'b1;
          cnt_d       = 2'd0;
        end
      endcase
    end
  end

  // State registers, cleared asynchronously so a partial triplet or pending result is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 2'd0;
      acc_q       <= '0;
      mode_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.in_index  = cnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_ternary_adder_serial_signed.sv
// tb/tb_ternary_adder_serial_signed.sv - scoreboard bench for the serial signed ternary adder
module tb_ternary_adder_serial_signed;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [1:0] tb_cnt = 2'd0;
  logic rand_ready = 1'b0;
  logic signed [W+1:0] sb_q[$];

  ternary_adder_serial_signed_if #(.width(W)) bus ();

  ternary_adder_serial_signed #(.width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every completed result transfer is compared with the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result observed=%0d expected=none", $signed(bus.out_data));
      end else begin
        chk("scoreboard", $signed(bus.out_data), sb_q.pop_front());
      end
    end
  end

  // Random downstream backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic signed [W+1:0] model(input int a, input int b, input int c, input logic [1:0] m);
    int r;
    if (m == 2'd0)      r = a + b + c;
    else if (m == 2'd1) r = a + b - c;
    else                r = a - b - c;
    return r[W+1:0];
  endfunction

  // Presents one beat and holds it until accepted; checks in_index on acceptance.
  task automatic send_beat(input logic [W-1:0] d, input logic [1:0] m);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $error("FAIL beat_timeout observed=stalled expected=accept");
    end
    chk("in_index", {30'd0, bus.in_index}, {30'd0, tb_cnt});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tb_cnt = (tb_cnt == 2'd2) ? 2'd0 : tb_cnt + 2'd1;
  endtask

  task automatic send_triplet(input int a, input int b, input int c, input logic [1:0] ma,
                              input logic [1:0] mbc, input bit push, input bit check_lat);
    logic signed [W+1:0] exp;
    logic [W-1:0] va, vb, vc;
    va = a[W-1:0];
    vb = b[W-1:0];
    vc = c[W-1:0];
    exp = model($signed(va), $signed(vb), $signed(vc), ma);
    send_beat(va, ma);
    send_beat(vb, mbc);
    if (push) sb_q.push_back(exp);
    send_beat(vc, mbc);
    if (check_lat) begin
      @(negedge clk);
      chk("latency_valid", {31'd0, bus.out_valid}, 32'sd1);
      chk("latency_data", $signed(bus.out_data), exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'sd0);
    chk("rst_in_index", {30'd0, bus.in_index}, 32'sd0);
    sb_q.delete();
    tb_cnt = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 2'd0;
    bus.out_ready = 1'b1;

    // Reset state.
    #2;
    chk("reset_in_index", {30'd0, bus.in_index}, 32'sd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'sd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'sd0);
    chk("reset_out_data", $signed(bus.out_data), 32'sd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed modes and extremes.
    send_triplet(100, 100, 100, 2'd0, 2'd0, 1'b1, 1'b1);
    chk("index_wrap", {30'd0, bus.in_index}, 32'sd0);
    send_triplet(-128, -128, 127, 2'd1, 2'd1, 1'b1, 1'b1);
    send_triplet(127, -128, -128, 2'd2, 2'd2, 1'b1, 1'b1);
    send_triplet(5, 3, 1, 2'd3, 2'd3, 1'b1, 1'b1);
    // Mode sampled only on the first beat.
    send_triplet(10, 20, 30, 2'd0, 2'd2, 1'b1, 1'b1);

    // Backpressure: result held, third beat stalls, then drain and load together.
    bus.out_ready = 1'b0;
    send_triplet(1, 2, 3, 2'd0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_held_valid", {31'd0, bus.out_valid}, 32'sd1);
    chk("bp_held_data", $signed(bus.out_data), 32'sd6);
    @(posedge clk);
    #1;
    send_beat(8'd4, 2'd0);
    send_beat(8'd5, 2'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'sd0);
      chk("bp_data_stable", $signed(bus.out_data), 32'sd6);
      @(posedge clk);
      #1;
    end
    sb_q.push_back(10'sd15);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_high", {31'd0, bus.in_ready}, 32'sd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tb_cnt = 2'd0;
    @(negedge clk);
    chk("bp_valid_kept", {31'd0, bus.out_valid}, 32'sd1);
    chk("bp_new_data", $signed(bus.out_data), 32'sd15);
    @(posedge clk);
    #1;

    // Reset after beat b.
    send_beat(8'd50, 2'd0);
    send_beat(8'd60, 2'd0);
    do_reset();
    // Reset while a result is stalled.
    bus.out_ready = 1'b0;
    send_triplet(1, 1, 1, 2'd0, 2'd0, 1'b0, 1'b0);
    send_beat(8'd9, 2'd1);
    do_reset();
    bus.out_ready = 1'b1;
    send_triplet(7, 8, 9, 2'd0, 2'd0, 1'b1, 1'b1);

    // Random streaming with gaps and backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      int a, b, c;
      logic [1:0] m;
      logic [7:0] ra, rb, rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      a = $signed(ra);
      b = $signed(rb);
      c = $signed(rc);
      m = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_triplet(a, b, c, m, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", sb_q.size(), 32'sd0);
    @(negedge clk);
    chk("final_out_valid", {31'd0, bus.out_valid}, 32'sd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
